// File: rtl/collide_arbiter.sv
// Round-robin arbiter sharing one collision-check port between requesters.
// One query in flight: capture, hold x/y for CHK_LAT cycles, return tagged result.
module collide_arbiter #(
    parameter int REQ_num  = 4,
    parameter int REQ_bits = 2,
    parameter int X_bits   = 8,
    parameter int Y_bits   = 7,
    parameter int CHK_LAT  = 2
) (
    input  logic                       Clk,
    input  logic                       RESET_SIM_N,
    input  logic [REQ_num-1:0]         req,
    input  logic [REQ_num*X_bits-1:0]  req_x,
    input  logic [REQ_num*Y_bits-1:0]  req_y,
    output logic [REQ_num-1:0]         grant,
    output logic [X_bits-1:0]          collide_x,
    output logic [Y_bits-1:0]          collide_y,
    input  logic                       collision,
    output logic                       rsp_valid,
    output logic [REQ_bits-1:0]        rsp_id,
    output logic                       rsp_collision,
    output logic                       busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int CW = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(CHK_LAT - 1);
    localparam logic [REQ_bits-1:0] ID_LAST = REQ_bits'(REQ_num - 1);

    logic [1:0]          r_state;
    logic [REQ_bits-1:0] r_rr_ptr;
    logic [CW-1:0]       r_wait_ctr;
    logic [REQ_bits-1:0] r_id;
    logic [X_bits-1:0]   r_x;
    logic [Y_bits-1:0]   r_y;
    logic [REQ_num-1:0]  r_grant;
    logic                r_rsp_valid;
    logic [REQ_bits-1:0] r_rsp_id;
    logic                r_rsp_collision;

    logic                w_found;
    logic [REQ_bits-1:0] w_pick;
    logic [REQ_bits-1:0] w_idx;
    logic [REQ_num-1:0]  w_onehot;
    int                  w_sum;

    // Scan from rr_ptr upward, wrapping at REQ_num (not a power of two in general)
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        w_sum   = 0;
        for (int k = 0; k < REQ_num; k++) begin
            w_sum = int'(r_rr_ptr) + k;
            if (w_sum >= REQ_num)
                w_sum = w_sum - REQ_num;
            w_idx = REQ_bits'(w_sum);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_onehot = {{(REQ_num-1){1'b0}}, 1'b1} << w_pick;

    always_ff @(posedge Clk) begin
        if (!RESET_SIM_N) begin
            r_state         <= S_IDLE;
            r_rr_ptr        <= '0;
            r_wait_ctr      <= '0;
            r_id            <= '0;
            r_x             <= '0;
            r_y             <= '0;
            r_grant         <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_id        <= '0;
            r_rsp_collision <= 1'b0;
        end else begin
            r_grant     <= '0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id       <= w_pick;
                        r_x        <= req_x[int'(w_pick)*X_bits +: X_bits];
                        r_y        <= req_y[int'(w_pick)*Y_bits +: Y_bits];
                        r_wait_ctr <= LAT_M1;
                        r_grant    <= w_onehot;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait_ctr == '0) begin
                        r_rsp_collision <= collision;
                        r_rsp_valid     <= 1'b1;
                        r_rsp_id        <= r_id;
                        r_state         <= S_RESP;
                    end else begin
                        r_wait_ctr <= r_wait_ctr - 1'b1;
                    end
                end
                S_RESP: begin
                    r_rr_ptr <= (r_id == ID_LAST) ? '0 : r_id + 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant         = r_grant;
    assign collide_x     = (r_state == S_WAIT) ? r_x : '0;
    assign collide_y     = (r_state == S_WAIT) ? r_y : '0;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_collision = r_rsp_collision;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_collide_arbiter.sv
// Bench for collide_arbiter: cycle table on a 4-req/2-latency instance,
// plus a hand-written sequence on a 3-req/1-latency instance.
module tb_collide_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: REQ_num=4, CHK_LAT=2
    logic        a_rst_n;
    logic [3:0]  a_req;
    logic [31:0] a_x;
    logic [27:0] a_y;
    logic [3:0]  a_grant;
    logic [7:0]  a_cx;
    logic [6:0]  a_cy;
    logic        a_col;
    logic        a_rv;
    logic [1:0]  a_rid;
    logic        a_rc;
    logic        a_busy;

    collide_arbiter #(
        .REQ_num(4), .REQ_bits(2), .X_bits(8), .Y_bits(7), .CHK_LAT(2)
    ) u_a (
        .Clk(clk), .RESET_SIM_N(a_rst_n),
        .req(a_req), .req_x(a_x), .req_y(a_y),
        .grant(a_grant), .collide_x(a_cx), .collide_y(a_cy),
        .collision(a_col), .rsp_valid(a_rv), .rsp_id(a_rid),
        .rsp_collision(a_rc), .busy(a_busy)
    );

    // instance B: REQ_num=3, CHK_LAT=1
    logic        b_rst_n;
    logic [2:0]  b_req;
    logic [23:0] b_x;
    logic [20:0] b_y;
    logic [2:0]  b_grant;
    logic [7:0]  b_cx;
    logic [6:0]  b_cy;
    logic        b_col;
    logic        b_rv;
    logic [1:0]  b_rid;
    logic        b_rc;
    logic        b_busy;

    collide_arbiter #(
        .REQ_num(3), .REQ_bits(2), .X_bits(8), .Y_bits(7), .CHK_LAT(1)
    ) u_b (
        .Clk(clk), .RESET_SIM_N(b_rst_n),
        .req(b_req), .req_x(b_x), .req_y(b_y),
        .grant(b_grant), .collide_x(b_cx), .collide_y(b_cy),
        .collision(b_col), .rsp_valid(b_rv), .rsp_id(b_rid),
        .rsp_collision(b_rc), .busy(b_busy)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] rq;
        logic       col;
        logic [3:0] g;
        logic [7:0] cx;
        logic [6:0] cy;
        logic       rv;
        logic [1:0] rid;
        logic       rc;
        logic       bz;
    } vec_t;

    vec_t tbl[$];
    logic [1:0] last_rid;
    logic       last_rc;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst_n, input logic [3:0] rq,
                       input logic col, input logic [3:0] g,
                       input int cx, input int cy, input logic rv,
                       input logic [1:0] rid, input logic rc,
                       input logic bz);
        vec_t v;
        v.rst_n = rst_n; v.rq = rq; v.col = col; v.g = g;
        v.cx = 8'(cx); v.cy = 7'(cy); v.rv = rv;
        v.rid = rid; v.rc = rc; v.bz = bz;
        tbl.push_back(v);
    endtask

    task automatic add_reset();
        last_rid = 2'd0;
        last_rc  = 1'b0;
        add(1'b0, 4'd0, 1'b0, 4'd0, 0, 0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic add_idle();
        add(1'b1, 4'd0, 1'b0, 4'd0, 0, 0, 1'b0, last_rid, last_rc, 1'b0);
    endtask

    // cols[k] is collision driven before the k-th edge of the query;
    // cols[2] is the one sampled at the end of the last WAIT cycle.
    task automatic add_query(input logic [3:0] rq, input int id,
                             input logic [3:0] cols);
        int x;
        int y;
        x = 40 + 10 * id;
        y = 30 + id;
        add(1'b1, rq, cols[0], 4'(1 << id), x, y, 1'b0, last_rid, last_rc, 1'b1);
        add(1'b1, rq, cols[1], 4'd0, x, y, 1'b0, last_rid, last_rc, 1'b1);
        last_rid = 2'(id);
        last_rc  = cols[2];
        add(1'b1, rq, cols[2], 4'd0, 0, 0, 1'b1, last_rid, last_rc, 1'b1);
        add(1'b1, rq, cols[3], 4'd0, 0, 0, 1'b0, last_rid, last_rc, 1'b0);
    endtask

    initial begin
        logic [23:0] act;
        logic [23:0] exp;
        a_rst_n = 1'b0; a_req = '0; a_col = 1'b0;
        a_x = {8'd70, 8'd60, 8'd50, 8'd40};
        a_y = {7'd33, 7'd32, 7'd31, 7'd30};
        b_rst_n = 1'b0; b_req = '0; b_col = 1'b0;
        b_x = {8'd102, 8'd101, 8'd100};
        b_y = {7'd12, 7'd11, 7'd10};

        // reset, idle, single query with collision tied high
        add_reset();
        add_reset();
        add_idle();
        add_query(4'b0001, 0, 4'b1111);
        // all four held: strict rotation from 0
        add_reset();
        for (int k = 0; k < 5; k++)
            add_query(4'b1111, k % 4, 4'b0000);
        // wrap past 3 back to 0, then 2
        add_query(4'b0100, 2, 4'b0000);
        add_query(4'b0101, 0, 4'b0000);
        add_query(4'b0101, 2, 4'b0000);
        // collision timing: only the last WAIT cycle counts
        add_query(4'b1000, 3, 4'b0100);
        add_query(4'b0001, 0, 4'b1011);
        // reset during second WAIT cycle of a query for id 3
        add(1'b1, 4'b1001, 1'b0, 4'b1000, 70, 33, 1'b0, last_rid, last_rc, 1'b1);
        add(1'b1, 4'b1001, 1'b1, 4'b0000, 70, 33, 1'b0, last_rid, last_rc, 1'b1);
        add_reset();
        add_query(4'b1001, 0, 4'b0000);
        add_idle();

        foreach (tbl[i]) begin
            @(negedge clk);
            a_rst_n = tbl[i].rst_n;
            a_req   = tbl[i].rq;
            a_col   = tbl[i].col;
            @(posedge clk);
            #1;
            act = {a_grant, a_cx, a_cy, a_rv, a_rid, a_rc, a_busy};
            exp = {tbl[i].g, tbl[i].cx, tbl[i].cy, tbl[i].rv,
                   tbl[i].rid, tbl[i].rc, tbl[i].bz};
            chk($sformatf("A_row%0d", i), 32'(act), 32'(exp));
        end

        // instance B: grant and sample share one cycle
        @(negedge clk);
        b_rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("B_reset", 32'({b_grant, b_cx, b_cy, b_rv, b_rid, b_rc, b_busy}), 32'd0);
        for (int k = 0; k < 7; k++) begin
            int  id;
            logic c;
            id = k % 3;
            c  = (k % 2) == 1;
            @(negedge clk);
            b_rst_n = 1'b1;
            b_req   = 3'b111;
            b_col   = ~c;
            @(posedge clk);
            #1;
            chk($sformatf("B_grant%0d", k),
                32'({b_grant, b_cx, b_cy, b_rv, b_busy}),
                32'({3'(1 << id), 8'(100 + id), 7'(10 + id), 1'b0, 1'b1}));
            @(negedge clk);
            b_col = c;
            @(posedge clk);
            #1;
            chk($sformatf("B_rsp%0d", k),
                32'({b_grant, b_cx, b_cy, b_rv, b_rid, b_rc, b_busy}),
                32'({3'd0, 8'd0, 7'd0, 1'b1, 2'(id), c, 1'b1}));
            @(negedge clk);
            b_col = ~c;
            @(posedge clk);
            #1;
            chk($sformatf("B_idle%0d", k),
                32'({b_grant, b_rv, b_rid, b_rc, b_busy}),
                32'({3'd0, 1'b0, 2'(id), c, 1'b0}));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/collide_arbiter.md
Name: collide_arbiter

Overview:
- Shares the single collision-check port (collide_x/collide_y in, collision out) between several requesters, e.g. nest/food setup, the ant update engine and the debug viewer.
- Accepts one coordinate query at a time using round-robin arbitration.
- Drives the checker and waits a fixed checker latency.
- Returns the result tagged with the requester id.
- Sits between the requesters and the collision checker in the sim top level.

Parameters:
REQ_num, 4, number of requesters (>=2, need not be a power of 2)
REQ_bits, 2, width of requester id (ceil(log2(REQ_num)))
X_bits, 8, x-coordinate width
Y_bits, 7, y-coordinate width
CHK_LAT, 2, cycles from collide_x/y stable to collision valid (>=1)

Ports:
Clk  in  1  system clock
RESET_SIM_N  in  1  synchronous active-low reset
req  in  REQ_num  per-requester query request, level
req_x  in  REQ_num x X_bits  per-requester query x
req_y  in  REQ_num x Y_bits  per-requester query y
grant  out  REQ_num  one-hot, 1-cycle pulse: query captured
collide_x  out  X_bits  x to collision checker
collide_y  out  Y_bits  y to collision checker
collision  in  1  checker result
rsp_valid  out  1  1-cycle pulse: result available
rsp_id  out  REQ_bits  requester owning the result
rsp_collision  out  1  sampled collision result
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (RESET_SIM_N low at a Clk edge): state=IDLE, rr_ptr=0, wait_ctr=0.
  - grant, rsp_valid, rsp_id, rsp_collision, collide_x, collide_y, busy and the latched id/x/y all 0.
  - Reset mid-operation discards the in-flight query; no rsp_valid is issued for it.
- IDLE: collide_x/y=0.
  - If any req bit is high at the edge, pick the first requester with req set, scanning from rr_ptr upward and wrapping from REQ_num-1 to 0.
  - Latch its id, req_x and req_y; set wait_ctr=CHK_LAT-1; go to WAIT.
  - No request: stay in IDLE.
- grant: registered. grant[id]=1 only in the first WAIT cycle (T+1 for capture at edge T); all other cycles 0.
- WAIT: collide_x/y = latched x/y, held constant for all CHK_LAT cycles.
  - wait_ctr decrements each cycle.
  - In the cycle wait_ctr==0, collision is sampled at the edge into rsp_collision; go to RESP.
  - WAIT lasts exactly CHK_LAT cycles. When CHK_LAT==1, the grant cycle is also the sample cycle.
- RESP (1 cycle):
  - rsp_valid=1; rsp_id=latched id; rsp_collision held.
  - collide_x/y return to 0.
  - rr_ptr <= id+1, wrapping to 0 when id==REQ_num-1.
  - Next state is IDLE; no arbitration happens in RESP.
  - Outside RESP, rsp_valid=0. rsp_id and rsp_collision keep their last values.
- Requester rule: hold req and req_x/y stable until grant is seen, then drop req the cycle after grant.
  - A req still high when the arbiter returns to IDLE is a new request.
  - req, req_x and req_y changes during WAIT/RESP are ignored.
- Latency: capture edge T → grant in cycle T+1 → rsp_valid in cycle T+CHK_LAT+1.
  - Minimum query period is CHK_LAT+2 cycles.
- Fairness: a continuously requesting requester waits at most REQ_num-1 other queries.
- Simultaneous requests: arbitration is decided only by rr_ptr order; x/y values have no effect.
- rr_ptr never holds a value >= REQ_num.

Test Plan:
1. Reset, then req=0001 with x=8'd40, y=7'd30 and collision tied 1 → grant=0001 at T+1; collide_x=40 and collide_y=30 for 2 cycles; rsp_valid at T+3 with rsp_id=0 and rsp_collision=1; busy high T+1..T+3.
2. req=1111 held continuously, collision=0 → grants in order 0001, 0010, 0100, 1000, 0001, one every 4 cycles; rsp_id sequence 0,1,2,3,0.
3. After a query served for id 2 (rr_ptr=3), assert req=0101 → id 0 is granted (wrap past 3 to 0); then rr_ptr=1, so id 2 is granted next.
4. Collision goes 0 → 1 in the last WAIT cycle only → rsp_collision=1. Collision high only in the first WAIT cycle (CHK_LAT=2) → rsp_collision=0.
5. Drop RESET_SIM_N in the second WAIT cycle → the next cycle shows state IDLE, busy=0, collide_x/y=0, no rsp_valid; the following query goes to id 0 first.
6. CHK_LAT=1 with REQ_num=3 and req=111 → grant and sample in the same cycle; rsp_valid 2 cycles after capture; ids cycle 0,1,2,0 and rr_ptr never reaches 3.
